enigma_stream_ctrl: RTL

Initiator and sequencer for the enigma core. It accepts an ASCII byte stream on a valid/ready interface and converts letters to 0-25 indices. For each letter it fires exactly one new_char_pulse, waits for the core path to settle after the rotor step, captures char_out, and returns an uppercase ASCII byte on an output valid/ready stream. It also issues load_key_cfg on request and tracks enciphered-letter count and error status.

---
 rtl/enigma_stream_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/enigma_stream_ctrl.sv
// Byte-stream sequencer for the enigma core: maps ASCII letters to indices, steps the core,
// captures its result and returns an uppercase byte. Optional build macro: ENIGMA_GROUP5_EN.
module enigma_stream_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    input  logic               load_key_req,
    output logic [4:0]         core_char_in,
    output logic               core_new_char_pulse,
    output logic               core_load_key,
    input  logic [4:0]         core_char_out,
    output logic [COUNT_W-1:0] char_count,
    output logic               err
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStep,
        StSettle,
        StOut
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [4:0]         char_in_q, char_in_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               err_q, err_d;
    logic               load_pend_q, load_pend_d;
    logic [3:0]         settle_q, settle_d;
`ifdef ENIGMA_GROUP5_EN
    logic [2:0]         grp_q, grp_d;
    logic               space_q, space_d;
`endif

    logic is_letter;
    logic load_any;
    logic out_done;

    assign is_letter = ((in_data >= 8'h41) && (in_data <= 8'h5A)) ||
                       ((in_data >= 8'h61) && (in_data <= 8'h7A));
    assign load_any  = load_key_req | load_pend_q;

    // Ready drops combinationally on a load request so a same-cycle byte is never taken.
    assign in_ready            = reset_n & (state_q == StIdle) & ~load_any;
    assign out_valid           = out_valid_q;
    assign out_data            = out_data_q;
    assign core_char_in        = char_in_q;
    assign core_new_char_pulse = (state_q == StStep);
    assign core_load_key       = (state_q == StLoad);
    assign char_count          = count_q;
    assign err                 = err_q;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        char_in_d   = char_in_q;
        count_d     = count_q;
        err_d       = err_q;
        load_pend_d = load_pend_q | load_key_req;
        settle_d    = settle_q;
        out_done    = 1'b0;
`ifdef ENIGMA_GROUP5_EN
        grp_d       = grp_q;
        space_d     = space_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (load_any) begin
                    state_d     = StLoad;
                    load_pend_d = 1'b0;
                end else if (in_valid) begin
                    if (is_letter) begin
                        // 'A' and 'a' both carry 5'd1 in their low bits.
                        char_in_d = in_data[4:0] - 5'd1;
                        state_d   = StStep;
                    end else begin
`ifndef ENIGMA_GROUP5_EN
                        out_data_d  = in_data;
                        out_valid_d = 1'b1;
                        state_d     = StOut;
`endif
                    end
                end
            end

            StLoad: begin
                count_d = '0;
                err_d   = 1'b0;
`ifdef ENIGMA_GROUP5_EN
                grp_d   = 3'd0;
                space_d = 1'b0;
`endif
                state_d = StIdle;
            end

            StStep: begin
                count_d  = count_q + 1'b1;
                settle_d = 4'd0;
                state_d  = StSettle;
            end

            StSettle: begin
                if (settle_q == 4'(SETTLE_CYCLES)) begin
                    if (core_char_out <= 5'd25) begin
                        out_data_d = 8'h41 + {3'b000, core_char_out};
                    end else begin
                        out_data_d = 8'h3F;
                        err_d      = 1'b1;
                    end
                    out_valid_d = 1'b1;
                    state_d     = StOut;
`ifdef ENIGMA_GROUP5_EN
                    if (grp_q == 3'd4) begin
                        grp_d   = 3'd0;
                        space_d = 1'b1;
                    end else begin
                        grp_d = grp_q + 3'd1;
                    end
`endif
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end

            StOut: begin
                if (out_ready) begin
`ifdef ENIGMA_GROUP5_EN
                    if (space_q) begin
                        out_data_d = 8'h20;
                        space_d    = 1'b0;
                    end else begin
                        out_done = 1'b1;
                    end
`else
                    out_done = 1'b1;
`endif
                end
            end

            default: state_d = StIdle;
        endcase

        // A load pending at the end of an output is serviced before re-entering idle.
        if (out_done) begin
            out_valid_d = 1'b0;
            char_in_d   = 5'd0;
            if (load_any) begin
                state_d     = StLoad;
                load_pend_d = 1'b0;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            char_in_q   <= 5'd0;
            count_q     <= '0;
            err_q       <= 1'b0;
            load_pend_q <= 1'b0;
            settle_q    <= 4'd0;
`ifdef ENIGMA_GROUP5_EN
            grp_q       <= 3'd0;
            space_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            char_in_q   <= char_in_d;
            count_q     <= count_d;
            err_q       <= err_d;
            load_pend_q <= load_pend_d;
            settle_q    <= settle_d;
`ifdef ENIGMA_GROUP5_EN
            grp_q       <= grp_d;
            space_q     <= space_d;
`endif
        end
    end

endmodule
